// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues req/gnt word requests to
// instruction memory, buffers in-order responses and feeds IF/ID one per cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0]   RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;
  logic [PW-1:0] pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   pq_q         [DEPTH];

  logic [CW:0]   credit_s;
  logic          grant_s;
  logic          resp_s;
  logic          keep_s;
  logic          pop_s;
  logic [31:0]   resp_pc_s;
  logic          unused_s;

  assign unused_s = ^redirect_pc[1:0];

  // Request credit: buffered plus in-flight entries may never exceed DEPTH.
  always_comb begin
    credit_s  = {1'b0, count_q} + {1'b0, outst_q};
    imem_req  = !reset && !redirect && (credit_s < DEPTH_W);
    imem_addr = pc_q;
    grant_s   = imem_req && imem_gnt;
    resp_s    = imem_rvalid && (outst_q != CW'(0));
    resp_pc_s = pq_q[pq_rd_q];
    keep_s    = resp_s && !redirect && (drop_q == CW'(0));
    f_valid   = !reset && (count_q != CW'(0));
    pop_s     = f_valid && !stall && !redirect;
    if (f_valid) begin
      f_instr = fifo_instr_q[f_rd_q];
      f_pc    = fifo_pc_q[f_rd_q];
    end else begin
      f_instr = 32'h0000_0000;
      f_pc    = 32'h0000_0000;
    end
  end

  // Next-state for PC, counters and queue pointers; redirect overrides push/pop.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    f_rd_d  = f_rd_q;
    f_wr_d  = f_wr_q;
    pq_rd_d = pq_rd_q;
    pq_wr_d = pq_wr_q;

    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (grant_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    case ({grant_s, resp_s})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (grant_s) begin
      pq_wr_d = ptr_inc(pq_wr_q);
    end else begin
      pq_wr_d = pq_wr_q;
    end
    if (resp_s) begin
      pq_rd_d = ptr_inc(pq_rd_q);
    end else begin
      pq_rd_d = pq_rd_q;
    end

    // drop_q only ever counts the oldest part of outst_q, so after a redirect
    // every request still in flight (minus one returning now) is stale.
    if (redirect) begin
      drop_d = outst_q - (resp_s ? CW'(1) : CW'(0));
    end else if (resp_s && (drop_q != CW'(0))) begin
      drop_d = drop_q - CW'(1);
    end else begin
      drop_d = drop_q;
    end

    if (redirect) begin
      count_d = '0;
      f_rd_d  = '0;
      f_wr_d  = '0;
    end else begin
      case ({keep_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      f_wr_d = keep_s ? ptr_inc(f_wr_q) : f_wr_q;
      f_rd_d = pop_s  ? ptr_inc(f_rd_q) : f_rd_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC_ALIGNED;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      f_rd_q  <= '0;
      f_wr_q  <= '0;
      pq_rd_q <= '0;
      pq_wr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      f_rd_q  <= f_rd_d;
      f_wr_q  <= f_wr_d;
      pq_rd_q <= pq_rd_d;
      pq_wr_q <= pq_wr_d;
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (keep_s) begin
      fifo_instr_q[f_wr_q] <= imem_rdata;
      fifo_pc_q[f_wr_q]    <= resp_pc_s;
    end
    if (grant_s) begin
      pq_q[pq_wr_q] <= pc_q;
    end
  end

  fetch_unit_checker u_chk (
    .clk_i        (clk),
    .reset_i      (reset),
    .rvalid_i     (imem_rvalid),
    .outst_zero_i (outst_q == CW'(0)),
    .push_i       (keep_s),
    .pop_i        (pop_s),
    .full_i       (count_q == DEPTH_C)
  );

endmodule

// Protocol checks for the fetch unit: no response without a request in
// flight, and no push into a full buffer that is not draining.
module fetch_unit_checker (
  input logic clk_i,
  input logic reset_i,
  input logic rvalid_i,
  input logic outst_zero_i,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(rvalid_i && outst_zero_i));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && full_i && !pop_i));

endmodule
